// File: rtl/can_pkg.sv
// Shared CAN transmit definitions: field widths, scheduler FSM states and
// the DLC clamp helper used when a frame is captured for can_tx.
package can_pkg;

  localparam int unsigned CAN_ID_W    = 11;
  localparam int unsigned CAN_DLC_W   = 4;
  localparam int unsigned CAN_DATA_W  = 64;
  localparam int unsigned CAN_MAX_DLC = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // Classic CAN carries at most 8 data bytes; larger codes map to 8.
  function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
    return (dlc > CAN_DLC_W'(CAN_MAX_DLC)) ? CAN_DLC_W'(CAN_MAX_DLC) : dlc;
  endfunction

endpackage

// File: rtl/can_prio_sel.sv
// Combinational arbitration among requesting mailboxes: lowest ID wins,
// equal IDs resolve to the lowest mailbox index.
//  req       in   NUM_MB           request vector
//  id        in   NUM_MB*CAN_ID_W  packed IDs, mailbox i at [i*11 +: 11]
//  win_idx   out  IDX_W            winning mailbox index
//  win_valid out  1                at least one request present
module can_prio_sel
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]          req,
  input  logic [NUM_MB*CAN_ID_W-1:0] id,
  output logic [IDX_W-1:0]           win_idx,
  output logic                       win_valid
);

  logic [CAN_ID_W-1:0] best_id;

  // Strict less-than keeps the earlier (lower) index on ID ties.
  always_comb begin
    best_id   = '1;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = 0; i < int'(NUM_MB); i++) begin
      if (req[i] && (!win_valid || (id[i*CAN_ID_W +: CAN_ID_W] < best_id))) begin
        best_id   = id[i*CAN_ID_W +: CAN_ID_W];
        win_idx   = IDX_W'(i);
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_mailbox_arb.sv
// Transmit mailbox scheduler in front of can_tx: picks the highest-priority
// pending mailbox, launches it, supervises busy/done and returns ack or err.
//  clk, rst             clock, asynchronous active-high reset
//  mb_req/id/dlc/data   host mailbox requests and packed frame fields
//  mb_ack, mb_err       one-cycle per-mailbox completion / timeout pulses
//  grant                one-hot owner of can_tx, 0 when idle
//  tx_start/id/dlc/data frame launch interface to can_tx
//  tx_busy, tx_done     can_tx status
module can_tx_mailbox_arb
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB   = 4,
  parameter int unsigned BUSY_TMO = 16,
  parameter int unsigned DONE_TMO = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MB-1:0]            mb_req,
  input  logic [NUM_MB*CAN_ID_W-1:0]   mb_id,
  input  logic [NUM_MB*CAN_DLC_W-1:0]  mb_dlc,
  input  logic [NUM_MB*CAN_DATA_W-1:0] mb_data,
  output logic [NUM_MB-1:0]            mb_ack,
  output logic [NUM_MB-1:0]            mb_err,
  output logic [NUM_MB-1:0]            grant,
  output logic                         tx_start,
  output logic [CAN_ID_W-1:0]          tx_id,
  output logic [CAN_DLC_W-1:0]         tx_dlc,
  output logic [CAN_DATA_W-1:0]        tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done
);

  localparam int unsigned IDX_W = $clog2(NUM_MB);
  localparam int unsigned TMR_W = $clog2(DONE_TMO) + 1;

  tx_state_e            state;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [CAN_ID_W-1:0]  sel_id;
  logic [CAN_DLC_W-1:0] sel_dlc;
  logic [CAN_DATA_W-1:0] sel_data;

  can_prio_sel #(
    .NUM_MB (NUM_MB),
    .IDX_W  (IDX_W)
  ) u_prio_sel (
    .req       (mb_req),
    .id        (mb_id),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Fields of the current arbitration winner.
  always_comb begin
    sel_id   = mb_id[int'(win_idx)*CAN_ID_W +: CAN_ID_W];
    sel_dlc  = clamp_dlc(mb_dlc[int'(win_idx)*CAN_DLC_W +: CAN_DLC_W]);
    sel_data = mb_data[int'(win_idx)*CAN_DATA_W +: CAN_DATA_W];
  end

  // Scheduler FSM; grant doubles as the one-hot for the ack/err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      mb_ack   <= '0;
      mb_err   <= '0;
      grant    <= '0;
      tx_start <= 1'b0;
      tx_id    <= '0;
      tx_dlc   <= '0;
      tx_data  <= '0;
    end else begin
      mb_ack   <= '0;
      mb_err   <= '0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant    <= NUM_MB'(1) << win_idx;
            tx_id    <= sel_id;
            tx_dlc   <= sel_dlc;
            tx_data  <= sel_data;
            tx_start <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          timer <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A fast can_tx may finish before busy is ever observed.
          if (tx_done) begin
            mb_ack <= grant;
            grant  <= '0;
            state  <= ST_IDLE;
          end else if (tx_busy) begin
            timer <= '0;
            state <= ST_WAIT_DONE;
          end else if (timer >= TMR_W'(BUSY_TMO - 1)) begin
            mb_err <= grant;
            grant  <= '0;
            state  <= ST_IDLE;
          end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            mb_ack <= grant;
            grant  <= '0;
            state  <= ST_IDLE;
          end else if (timer >= TMR_W'(DONE_TMO - 1)) begin
            mb_err <= grant;
            grant  <= '0;
            state  <= ST_IDLE;
          end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arb.sv
// Scoreboard bench for can_tx_mailbox_arb: a host model issues mailbox batches,
// a reference model predicts the send order and outcome, a can_tx model answers
// the launches, and a monitor checks every launch and completion.
module tb_can_tx_mailbox_arb;

  localparam int unsigned NUM_MB   = 4;
  localparam int unsigned BUSY_TMO = 16;
  localparam int unsigned DONE_TMO = 64;

  // can_tx model behaviour per mailbox
  localparam int M_NORMAL  = 0;  // busy then done
  localparam int M_NOBUSY  = 1;  // never answers -> busy timeout
  localparam int M_FASTDN  = 2;  // done without busy
  localparam int M_NODONE  = 3;  // busy forever -> done timeout

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_MB-1:0]    mb_req = '0;
  logic [10:0]          id_a   [NUM_MB];
  logic [3:0]           dlc_a  [NUM_MB];
  logic [63:0]          data_a [NUM_MB];
  int                   mode_a [NUM_MB];
  logic [NUM_MB*11-1:0] mb_id;
  logic [NUM_MB*4-1:0]  mb_dlc;
  logic [NUM_MB*64-1:0] mb_data;
  logic [NUM_MB-1:0]    mb_ack, mb_err, grant;
  logic                 tx_start;
  logic [10:0]          tx_id;
  logic [3:0]           tx_dlc;
  logic [63:0]          tx_data;
  logic                 tx_busy = 1'b0;
  logic                 tx_done = 1'b0;

  typedef struct {
    int          idx;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    bit          ack;
    int          mode;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   inflight  = 1'b0;
  bit   prev_start = 1'b0;
  bit   prev_done  = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < int'(NUM_MB); i++) begin
      mb_id[i*11 +: 11]   = id_a[i];
      mb_dlc[i*4 +: 4]    = dlc_a[i];
      mb_data[i*64 +: 64] = data_a[i];
    end
  end

  can_tx_mailbox_arb #(
    .NUM_MB   (NUM_MB),
    .BUSY_TMO (BUSY_TMO),
    .DONE_TMO (DONE_TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mb_req   (mb_req),
    .mb_id    (mb_id),
    .mb_dlc   (mb_dlc),
    .mb_data  (mb_data),
    .mb_ack   (mb_ack),
    .mb_err   (mb_err),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_id    (tx_id),
    .tx_dlc   (tx_dlc),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: frames leave in ascending (id, index) order; outcome by model mode.
  task automatic push_expected(input logic [NUM_MB-1:0] req);
    logic [NUM_MB-1:0] rem;
    int best, best_key, key;
    exp_t e;
    rem = req;
    while (rem != '0) begin
      best = -1;
      best_key = 0;
      for (int i = 0; i < int'(NUM_MB); i++) begin
        key = int'(id_a[i]) * int'(NUM_MB) + i;
        if (rem[i] && (best < 0 || key < best_key)) begin
          best = i;
          best_key = key;
        end
      end
      e.idx  = best;
      e.id   = id_a[best];
      e.dlc  = (dlc_a[best] > 4'd8) ? 4'd8 : dlc_a[best];
      e.data = data_a[best];
      e.mode = mode_a[best];
      e.ack  = (mode_a[best] == M_NORMAL) || (mode_a[best] == M_FASTDN);
      sb.push_back(e);
      rem[best] = 1'b0;
    end
  endtask

  // Monitor: compares every launch and completion against the scoreboard.
  always @(negedge clk) begin
    logic [NUM_MB-1:0] oh;
    if (rst) begin
      sb.delete();
      inflight   = 1'b0;
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_start) check("start_width", 64'(tx_start), 64'(0));
      if (tx_start) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 64'(1), 64'(0));
        end else begin
          cur = sb.pop_front();
          inflight  = 1'b1;
          start_cyc = cyc;
          oh = NUM_MB'(1) << cur.idx;
          check("grant", 64'(grant), 64'(oh));
          check("tx_id", 64'(tx_id), 64'(cur.id));
          check("tx_dlc", 64'(tx_dlc), 64'(cur.dlc));
          check("tx_data", tx_data, cur.data);
        end
      end
      if ((mb_ack != '0) || (mb_err != '0)) begin
        if (!inflight) begin
          check("unexpected_done", 64'({mb_ack, mb_err}), 64'(0));
        end else begin
          oh = NUM_MB'(1) << cur.idx;
          check("mb_ack", 64'(mb_ack), cur.ack ? 64'(oh) : 64'(0));
          check("mb_err", 64'(mb_err), cur.ack ? 64'(0) : 64'(oh));
          check("grant_clear", 64'(grant), 64'(0));
          check("tx_id_hold", 64'(tx_id), 64'(cur.id));
          check("tx_data_hold", tx_data, cur.data);
          if (cur.ack) check("ack_after_done", 64'(prev_done), 64'(1));
          if (cur.mode == M_NOBUSY)
            check("busy_tmo_cycles",
                  64'((cyc - start_cyc >= int'(BUSY_TMO)) && (cyc - start_cyc <= int'(BUSY_TMO) + 2)),
                  64'(1));
          inflight = 1'b0;
        end
      end
      prev_start = tx_start;
      prev_done  = tx_done;
    end
  end

  // can_tx model: reacts to each launch according to the granted mailbox's mode.
  initial begin
    int idx, n;
    forever begin
      @(posedge clk); #1;
      if (tx_start && !rst) begin
        idx = 0;
        for (int i = 0; i < int'(NUM_MB); i++) if (grant[i]) idx = i;
        case (mode_a[idx])
          M_NORMAL: begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            tx_busy = 1'b1;
            repeat ($urandom_range(1, 10)) begin @(posedge clk); #1; end
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
          end
          M_FASTDN: begin
            repeat (2) begin @(posedge clk); #1; end
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
          end
          M_NODONE: begin
            tx_busy = 1'b1;
            n = 0;
            while ((mb_err == '0) && !rst && n < int'(DONE_TMO) + 40) begin
              @(posedge clk); #1;
              n++;
            end
            tx_busy = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Host model: request a batch, drop each request on its ack/err, scramble the
  // granted mailbox's fields after launch, wait until everything drains.
  task automatic run_batch(input logic [NUM_MB-1:0] req);
    int g;
    bit drained;
    drained = 1'b0;
    @(negedge clk);
    push_expected(req);
    mb_req = req;
    @(negedge clk);
    if (req != '0) check("launch_latency", 64'(tx_start), 64'(1));
    for (int c = 0; c < int'(NUM_MB) * (int'(DONE_TMO) + 60) + 50; c++) begin
      mb_req = mb_req & ~(mb_ack | mb_err);
      if ((grant != '0) && !tx_start && ($urandom_range(0, 1) == 1)) begin
        g = 0;
        for (int i = 0; i < int'(NUM_MB); i++) if (grant[i]) g = i;
        id_a[g]   = 11'($urandom);
        dlc_a[g]  = 4'($urandom);
        data_a[g] = {$urandom, $urandom};
      end
      if ((mb_req == '0) && (grant == '0) && (sb.size() == 0)) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!drained) check("batch_timeout", 64'(1), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] dlc, input int mode);
    id_a[i]   = id;
    dlc_a[i]  = dlc;
    data_a[i] = {$urandom, $urandom};
    mode_a[i] = mode;
  endtask

  initial begin
    int r;
    bit seen;
    for (int i = 0; i < int'(NUM_MB); i++) set_mb(i, 11'h7FF, 4'd0, M_NORMAL);
    repeat (3) @(negedge clk);
    check("rst_mb_ack", 64'(mb_ack), 64'(0));
    check("rst_mb_err", 64'(mb_err), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_id", 64'(tx_id), 64'(0));
    check("rst_tx_dlc", 64'(tx_dlc), 64'(0));
    check("rst_tx_data", tx_data, 64'(0));
    rst = 1'b0;

    // single request
    set_mb(0, 11'h123, 4'd2, M_NORMAL);
    run_batch(4'b0001);

    // priority order 1,3,0,2
    set_mb(0, 11'h300, 4'd1, M_NORMAL);
    set_mb(1, 11'h0A5, 4'd3, M_NORMAL);
    set_mb(2, 11'h7FF, 4'd8, M_NORMAL);
    set_mb(3, 11'h0A5, 4'd5, M_NORMAL);
    run_batch(4'b1111);

    // DLC clamp
    set_mb(0, 11'h010, 4'hF, M_NORMAL);
    run_batch(4'b0001);

    // busy timeout, then the next request is served
    set_mb(2, 11'h055, 4'd4, M_NOBUSY);
    run_batch(4'b0100);
    set_mb(2, 11'h056, 4'd4, M_NORMAL);
    run_batch(4'b0100);

    // done without busy, and done timeout
    set_mb(1, 11'h200, 4'd6, M_FASTDN);
    run_batch(4'b0010);
    set_mb(3, 11'h201, 4'd7, M_NODONE);
    run_batch(4'b1000);

    // reset during WAIT_DONE
    set_mb(0, 11'h111, 4'd3, M_NODONE);
    @(negedge clk);
    push_expected(4'b0001);
    mb_req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_busy && (grant != '0)) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_wait_done", 64'(seen), 64'(1));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    mb_req = '0;
    repeat (2) @(negedge clk);
    check("midrst_grant", 64'(grant), 64'(0));
    check("midrst_tx_start", 64'(tx_start), 64'(0));
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("postrst_quiet", 64'({mb_ack, mb_err, grant, tx_start}), 64'(0));
    end
    set_mb(0, 11'h112, 4'd2, M_NORMAL);
    run_batch(4'b0001);

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < int'(NUM_MB); i++) begin
        id_a[i]   = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 3)) : 11'($urandom);
        dlc_a[i]  = 4'($urandom);
        data_a[i] = {$urandom, $urandom};
        r = int'($urandom_range(0, 9));
        mode_a[i] = (r < 6) ? M_NORMAL : (r < 8) ? M_FASTDN : (r == 8) ? M_NOBUSY : M_NODONE;
      end
      run_batch(NUM_MB'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
